// File: rtl/reg_write_queue.sv
// Posted register-file write queue: buffers write requests in a circular FIFO,
// drains one per cycle when the register file is not stalled, and forwards pending data.
module reg_write_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [4:0]                 in_reg,
  input  logic [31:0]                in_data,
  output logic                       in_ready,
  input  logic                       rf_stall,
  output logic                       rf_RegWrite,
  output logic [4:0]                 rf_WriteReg,
  output logic [31:0]                rf_WriteData,
  input  logic [4:0]                 ReadReg1,
  input  logic [4:0]                 ReadReg2,
  output logic                       fwd_hit1,
  output logic                       fwd_hit2,
  output logic [31:0]                fwd_data1,
  output logic [31:0]                fwd_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  logic [RW-1:0] reg_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic push;
  logic pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == CW'(0));
  assign count = count_q;

  // Handshake: a pop frees a slot in the same cycle, so a full queue still accepts.
  assign rf_RegWrite = !empty && !rf_stall && !reset;
  assign pop         = rf_RegWrite;
  assign in_ready    = !reset && (!full || pop);
  assign push        = in_valid && in_ready;

  assign rf_WriteReg  = (empty || reset) ? RW'(0) : reg_mem[head_q];
  assign rf_WriteData = (empty || reset) ? DW'(0) : data_mem[head_q];

  // Pointer and occupancy state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      head_q  <= PW'(0);
      tail_q  <= PW'(0);
      count_q <= CW'(0);
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage is not cleared on reset; occupancy alone defines validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      reg_mem[tail_q]  <= in_reg;
      data_mem[tail_q] <= in_data;
    end
  end

  // Forwarding: scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = DW'(0);
    fwd_data2 = DW'(0);
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) < count_q) begin
          if (reg_mem[PW'(head_q + PW'(i))] == ReadReg1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = data_mem[PW'(head_q + PW'(i))];
          end
          if (reg_mem[PW'(head_q + PW'(i))] == ReadReg2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = data_mem[PW'(head_q + PW'(i))];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench for reg_write_queue: accepted pushes queue expected writes,
// a negedge monitor checks every register-file write against them.
module tb_reg_write_queue;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  in_reg = '0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        rf_stall = 1'b0;
  logic        rf_RegWrite;
  logic [4:0]  rf_WriteReg;
  logic [31:0] rf_WriteData;
  logic [4:0]  ReadReg1 = '0;
  logic [4:0]  ReadReg2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;
  logic        full, empty;

  int n_cmp = 0;
  int n_bad = 0;
  logic [36:0] exp_q[$];

  reg_write_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_reg(in_reg), .in_data(in_data),
    .in_ready(in_ready), .rf_stall(rf_stall), .rf_RegWrite(rf_RegWrite),
    .rf_WriteReg(rf_WriteReg), .rf_WriteData(rf_WriteData), .ReadReg1(ReadReg1),
    .ReadReg2(ReadReg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1),
    .fwd_data2(fwd_data2), .count(count), .full(full), .empty(empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expected entry.
  always @(negedge CLK) begin
    if (reset) begin
      chk("rst_regwrite", 32'(rf_RegWrite), 32'd0);
    end else begin
      chk("regwrite_rule", 32'(rf_RegWrite), 32'(!empty && !rf_stall));
      if (rf_RegWrite) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(rf_WriteReg), 32'hFFFF_FFFF);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("wr_reg", 32'(rf_WriteReg), 32'(e[36:32]));
          chk("wr_data", rf_WriteData, e[31:0]);
        end
      end else if (empty) begin
        chk("idle_wreg", 32'(rf_WriteReg), 32'd0);
      end
    end
  end

  // Present a request from posedge+1 until accepted; record it when the handshake is seen.
  task automatic push(input logic [4:0] r, input logic [31:0] d);
    bit done = 0;
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge CLK);
      if (in_ready) begin
        exp_q.push_back({r, d});
        done = 1;
      end
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'(r), 32'hFFFF_FFFF);
  endtask

  task automatic wait_empty();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge CLK);
      if (empty) done = 1;
      else begin
        @(posedge CLK);
        #1;
      end
    end
    chk("drain_done", 32'(done), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_full", 32'(full), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge CLK);
    #1;

    // Single write: no pass-through, no forwarding of the in-flight request
    in_valid = 1'b1; in_reg = 5'd5; in_data = 32'hDEADBEEF; ReadReg1 = 5'd5;
    @(negedge CLK);
    chk("no_passthru", 32'(rf_RegWrite), 32'd0);
    chk("no_fwd_inflight", 32'(fwd_hit1), 32'd0);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("single_regwrite", 32'(rf_RegWrite), 32'd1);
    chk("fwd_popping_entry", fwd_data1, 32'hDEADBEEF);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("single_empty_after", 32'(empty), 32'd1);
    @(posedge CLK);
    #1;

    // Fill under stall, then drain on four consecutive cycles
    rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11));
    @(negedge CLK);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_not_empty", 32'(empty), 32'd0);
    @(posedge CLK);
    #1;
    rf_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      chk("consec_regwrite", 32'(rf_RegWrite), 32'd1);
      chk("consec_reg", 32'(rf_WriteReg), 32'(i));
      @(posedge CLK);
      #1;
    end
    wait_empty();

    // Full with simultaneous push and pop
    rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11));
    rf_stall = 1'b0;
    push(5'd7, 32'h77);
    @(negedge CLK);
    chk("full_pushpop_count", 32'(count), 32'd4);
    @(posedge CLK);
    #1;
    wait_empty();

    // Youngest-entry forwarding, including register 0
    rf_stall = 1'b1;
    push(5'd9, 32'hA);
    push(5'd9, 32'hB);
    push(5'd0, 32'h5A);
    ReadReg1 = 5'd9; ReadReg2 = 5'd8;
    @(negedge CLK);
    chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
    chk("fwd_data1_young", fwd_data1, 32'hB);
    chk("fwd_hit2_miss", 32'(fwd_hit2), 32'd0);
    chk("fwd_data2_miss", fwd_data2, 32'd0);
    ReadReg2 = 5'd0;
    #1;
    chk("fwd_r0_hit", 32'(fwd_hit2), 32'd1);
    chk("fwd_r0_data", fwd_data2, 32'h5A);
    @(posedge CLK);
    #1;
    rf_stall = 1'b0;
    wait_empty();

    // Reset mid-drain discards entries and the request on the reset edge
    rf_stall = 1'b1;
    push(5'd10, 32'h1);
    push(5'd11, 32'h2);
    push(5'd12, 32'h3);
    ReadReg1 = 5'd10;
    @(negedge CLK);
    chk("pre_rst_fwd", 32'(fwd_hit1), 32'd1);
    @(posedge CLK);
    #1;
    rf_stall = 1'b0; reset = 1'b1;
    in_valid = 1'b1; in_reg = 5'd13; in_data = 32'h13;
    exp_q.delete();
    @(negedge CLK);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid_fwd_hit1", 32'(fwd_hit1), 32'd0);
    chk("rst_mid_fwd_data1", fwd_data1, 32'd0);
    chk("rst_mid_wreg", 32'(rf_WriteReg), 32'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0; in_valid = 1'b0; ReadReg1 = 5'd13;
    @(negedge CLK);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_after_wr", 32'(rf_RegWrite), 32'd0);
    chk("rst_dropped_fwd", 32'(fwd_hit1), 32'd0);
    @(posedge CLK);
    #1;

    // Wrap-around with random stall
    fork
      begin
        for (int i = 0; i < 10; i++) push(5'(i), 32'(i) * 32'h100);
      end
      begin
        repeat (40) begin
          rf_stall = 1'($urandom_range(0, 1));
          @(posedge CLK);
          #1;
        end
        rf_stall = 1'b0;
      end
    join
    wait_empty();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
